// File: rtl/queue_pkg.sv
// Shared constants and types for the circular FIFO queue and its pointer sub-module.
package queue_pkg;

    localparam int QUEUE_WIDTH = 16;
    localparam int QUEUE_DEPTH = 8;
    localparam int QUEUE_AW    = 3;

    typedef logic [QUEUE_WIDTH-1:0] queue_word_t;
    typedef logic [QUEUE_AW-1:0]    queue_ptr_t;

endpackage

// File: rtl/queue_ptr.sv
// Wrapping read/write pointer for the queue: AW-bit counter, async reset to 0, increment-enable.
module queue_ptr
    import queue_pkg::*;
#(
    parameter int AW = QUEUE_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    // DEPTH is a power of two, so natural AW-bit overflow is the modulo-DEPTH wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/queue.sv
// Circular first-word-fall-through FIFO; head entry always visible on value_out.
// Optional sticky protocol-error output err is built when QUEUE_ERR_EN is defined.
module queue
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int AW    = QUEUE_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] value_out,
    output logic [AW:0]      count,
`ifdef QUEUE_ERR_EN
    output logic             full,
    output logic             empty,
    output logic             err
`else
    output logic             full,
    output logic             empty
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    // Flags decode only the registered count, never the requests
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign value_out = empty ? '0 : mem[head];

    queue_ptr #(.AW(AW)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (do_pop),
        .ptr   (head)
    );

    queue_ptr #(.AW(AW)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (do_push),
        .ptr   (tail)
    );

    // Storage is deliberately not reset; the empty gate hides stale words
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= value_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef QUEUE_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((push & full) | (pop & empty)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
